cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- Execution datapath consuming the per-cycle control strobes of the CPU controller state machine.
- Holds the 16-bit instruction register (assembled from two byte fetches), the program counter, the accumulator and ALU, and the memory address mux.
- Returns opcode and zero to the controller and drives address and data onto the memory bus.

Parameters:
- DATA_W, 8, data/accumulator width in bits; instruction width is 2*DATA_W.
- ADDR_W, 13, address and PC width; constraint ADDR_W + 3 == 2*DATA_W; opcode is the top 3 IR bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- inc_pc  in  1  PC increment strobe.
- load_pc  in  1  PC load-from-IR-address strobe.
- load_acc  in  1  accumulator load-from-ALU strobe.
- load_ir  in  1  IR byte load strobe.
- rd  in  1  memory read request.
- wr  in  1  memory write request.
- datactl_ena  in  1  accumulator bus drive enable.
- halt  in  1  halt request.
- fetch  in  1  address select: 1 = PC, 0 = IR address field.
- data_in  in  DATA_W  memory read data.
- data_out  out  DATA_W  accumulator value for the bus; equals acc at all times.
- data_oe  out  1  bus drive enable; equals datactl_ena and not halted.
- addr  out  ADDR_W  memory address; combinational mux of pc and ir_addr.
- mem_rd  out  1  rd and not halted.
- mem_wr  out  1  wr and not halted.
- opcode  out  3  IR[2*DATA_W-1 -: 3].
- zero  out  1  1 when acc == 0; combinational from the acc register.
- halted  out  1  sticky halt status.
- bus_err  out  1  sticky flag: rd and wr sampled high in the same cycle.
- instr_cnt  out  16  count of completed two-byte instruction fetches.

Behaviour:
- Reset (rst high at a clock edge):
  - pc=0, acc=0, ir=0, byte_ptr=0, halted=0, bus_err=0, instr_cnt=0.
  - Resulting outputs: opcode=0 (HLT), zero=1, addr=0, data_oe=0, mem_rd=0, mem_wr=0.
  - rst has priority over every strobe.
  - rst asserted mid-instruction discards any partially loaded IR byte.
- IR load:
  - byte_ptr is internal, 1 bit.
  - load_ir=1, byte_ptr=0: IR[15:8] <= data_in, byte_ptr <= 1.
  - load_ir=1, byte_ptr=1: IR[7:0] <= data_in, byte_ptr <= 0, instr_cnt <= instr_cnt+1 (wraps 65535 to 0).
  - Any cycle with load_ir=0 forces byte_ptr <= 0. A lone single-cycle load_ir therefore updates only the high byte and does not increment instr_cnt.
  - ir_addr = IR[ADDR_W-1:0].
- PC:
  - load_pc has priority over inc_pc. If both are high, pc <= ir_addr (the controller asserts both on a jump).
  - inc_pc alone: pc <= pc+1, wrapping 2^ADDR_W-1 to 0.
- Accumulator (load_acc=1): acc <= alu(opcode).
  - ADD (010): acc+data_in, mod 2^DATA_W, carry discarded.
  - ANDD (011): acc & data_in.
  - XORR (100): acc ^ data_in.
  - LDA (101): data_in.
  - HLT, SKZ, STO, JMP: acc unchanged.
  - The ALU uses the opcode and data_in present in the same cycle; load latency is 1 clock.
- Halt:
  - halt sampled high sets halted <= 1 at that edge. Strobes in that same cycle (e.g. inc_pc) still take effect.
  - From the following cycle on, inc_pc, load_pc, load_acc and load_ir are ignored, and mem_rd, mem_wr and data_oe are forced to 0.
  - halted clears only on rst.
- Bus error: rd and wr both high at an edge sets bus_err <= 1, sticky until rst. No other effect; mem_rd/mem_wr still follow their inputs.
- Addressing: addr = fetch ? pc : ir_addr, with zero-cycle latency.

Test Plan:
- Reset, then idle: opcode=0, zero=1, addr=0, instr_cnt=0, data_oe=0.
- Fetch: load_ir for 2 cycles with data_in=0xA0 then 0x05 -> IR=0xA005, opcode=101 (LDA), ir_addr=0x0005, instr_cnt=1. fetch=0 gives addr=0x0005.
- ALU:
  - LDA with data_in=0x7F -> acc=0x7F, zero=0.
  - Then IR opcode ADD with data_in=0x81 -> acc=0x00, zero=1 (wrap).
  - Then XORR with 0xFF -> acc=0xFF.
- PC: pc=0x1FFF, inc_pc -> pc=0x0000. IR=0xE123 with load_pc=1 and inc_pc=1 together -> pc=0x0123.
- Halt: halt=1 with inc_pc=1 at pc=4 -> pc=5 and halted=1. Subsequent inc_pc/load_ir/load_acc leave pc/IR/acc unchanged and mem_rd=0. rst clears halted and pc.
- Boundaries:
  - Single load_ir pulse with 0x3C -> IR high byte=0x3C, instr_cnt unchanged, next load_ir writes the high byte again.
  - rd=wr=1 for one cycle -> bus_err=1, held until rst.

Source files
------------

// File: rtl/cpu_datapath.sv
// Execution datapath for the two-byte-instruction accumulator CPU: IR, PC, accumulator/ALU
// and the memory address mux, sequenced by strobes from the controller FSM.
module cpu_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              load_acc,
  input  logic              load_ir,
  input  logic              rd,
  input  logic              wr,
  input  logic              datactl_ena,
  input  logic              halt,
  input  logic              fetch,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic [ADDR_W-1:0] addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        opcode,
  output logic              zero,
  output logic              halted,
  output logic              bus_err,
  output logic [15:0]       instr_cnt
);
  localparam int IR_W = 2 * DATA_W;

  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              ptr_q, ptr_d;
  logic              halted_q, halted_d;
  logic              bus_err_q, bus_err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] ir_addr;
  logic              active;

  assign ir_addr = ir_q[ADDR_W-1:0];
  assign active  = ~halted_q;

  always_comb begin
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    ptr_d     = 1'b0;
    cnt_d     = cnt_q;
    halted_d  = halted_q | halt;
    bus_err_d = bus_err_q | (rd & wr);

    // A gap in load_ir realigns the byte pointer, so a stray pulse never pairs with a later one.
    if (load_ir && active) begin
      if (!ptr_q) begin
        ir_d[IR_W-1:DATA_W] = data_in;
        ptr_d               = 1'b1;
      end else begin
        ir_d[DATA_W-1:0] = data_in;
        cnt_d            = cnt_q + 16'd1;
      end
    end

    if (active) begin
      if (load_pc)     pc_d = ir_addr;
      else if (inc_pc) pc_d = pc_q + 1'b1;
    end

    if (load_acc && active) begin
      unique case (opcode)
        OP_ADD:  acc_d = acc_q + data_in;
        OP_ANDD: acc_d = acc_q & data_in;
        OP_XORR: acc_d = acc_q ^ data_in;
        OP_LDA:  acc_d = data_in;
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      acc_q     <= '0;
      ir_q      <= '0;
      ptr_q     <= 1'b0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      ir_q      <= ir_d;
      ptr_q     <= ptr_d;
      halted_q  <= halted_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign opcode    = ir_q[IR_W-1 -: 3];
  assign addr      = fetch ? pc_q : ir_addr;
  assign data_out  = acc_q;
  assign data_oe   = datactl_ena & active;
  assign mem_rd    = rd & active;
  assign mem_wr    = wr & active;
  assign zero      = (acc_q == '0);
  assign halted    = halted_q;
  assign bus_err   = bus_err_q;
  assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Scenario bench for cpu_datapath: expectations queued when stimulus is applied,
// popped and compared once the DUT has responded.
module tb_cpu_datapath;
  logic        clk = 1'b0;
  logic        rst, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, fetch;
  logic [7:0]  data_in, data_out;
  logic        data_oe, mem_rd, mem_wr, zero, halted, bus_err;
  logic [12:0] addr;
  logic [2:0]  opcode;
  logic [15:0] instr_cnt;

  typedef struct { string nm; logic [31:0] v; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   n_run = 0;
  int   n_fail = 0;

  cpu_datapath #(.DATA_W(8), .ADDR_W(13)) dut (
    .clk(clk), .rst(rst), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
    .load_ir(load_ir), .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt),
    .fetch(fetch), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .addr(addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .opcode(opcode), .zero(zero),
    .halted(halted), .bus_err(bus_err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; inc_pc = 0; load_pc = 0; load_acc = 0; load_ir = 0;
    rd = 0; wr = 0; datactl_ena = 0; halt = 0; fetch = 1; data_in = 8'h00;
  endtask

  task automatic load_instr(input logic [7:0] hi, input logic [7:0] lo);
    load_ir = 1; data_in = hi; tick();
    data_in = lo; tick();
    load_ir = 0; data_in = 8'h00;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    e = sb.pop_front();
    n_run++;
    if (obs !== e.v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", e.nm, obs, e.v);
    end
  endtask

  task automatic test_reset();
    do_reset();
    sb.push_back('{"rst_opcode", 32'd0});
    sb.push_back('{"rst_zero", 32'd1});
    sb.push_back('{"rst_addr", 32'd0});
    sb.push_back('{"rst_instr_cnt", 32'd0});
    sb.push_back('{"rst_data_oe", 32'd0});
    sb.push_back('{"rst_mem_rd", 32'd0});
    tick();
    pop_cmp(32'(opcode)); pop_cmp(32'(zero)); pop_cmp(32'(addr));
    pop_cmp(32'(instr_cnt)); pop_cmp(32'(data_oe)); pop_cmp(32'(mem_rd));
  endtask

  task automatic test_fetch();
    sb.push_back('{"fetch_opcode", 32'd5});
    sb.push_back('{"fetch_instr_cnt", 32'd1});
    sb.push_back('{"fetch_ir_addr", 32'h0005});
    load_instr(8'hA0, 8'h05);
    fetch = 0; #1;
    pop_cmp(32'(opcode)); pop_cmp(32'(instr_cnt)); pop_cmp(32'(addr));
    fetch = 1;
  endtask

  task automatic test_alu();
    load_acc = 1; data_in = 8'h7F;
    sb.push_back('{"lda_acc", 32'h7F}); sb.push_back('{"lda_zero", 32'd0});
    tick(); load_acc = 0;
    pop_cmp(32'(data_out)); pop_cmp(32'(zero));

    load_instr(8'h40, 8'h00);
    load_acc = 1; data_in = 8'h81;
    sb.push_back('{"add_wrap_acc", 32'h00}); sb.push_back('{"add_wrap_zero", 32'd1});
    tick(); load_acc = 0;
    pop_cmp(32'(data_out)); pop_cmp(32'(zero));

    load_instr(8'h80, 8'h00);
    load_acc = 1; data_in = 8'hFF;
    sb.push_back('{"xor_acc", 32'hFF});
    tick(); load_acc = 0;
    pop_cmp(32'(data_out));

    load_instr(8'h60, 8'h00);
    load_acc = 1; data_in = 8'h0F;
    sb.push_back('{"and_acc", 32'h0F});
    tick(); load_acc = 0;
    pop_cmp(32'(data_out));

    load_instr(8'hC0, 8'h00); // STO leaves acc untouched
    load_acc = 1; data_in = 8'h55;
    sb.push_back('{"sto_acc_hold", 32'h0F});
    sb.push_back('{"alu_instr_cnt", 32'd5});
    tick(); load_acc = 0;
    pop_cmp(32'(data_out)); pop_cmp(32'(instr_cnt));
  endtask

  task automatic test_pc();
    load_instr(8'h1F, 8'hFF);
    load_pc = 1;
    sb.push_back('{"pc_load_1fff", 32'h1FFF});
    tick(); load_pc = 0;
    pop_cmp(32'(addr));

    inc_pc = 1;
    sb.push_back('{"pc_wrap", 32'h0000});
    tick(); inc_pc = 0;
    pop_cmp(32'(addr));

    load_instr(8'hE1, 8'h23);
    load_pc = 1; inc_pc = 1;
    sb.push_back('{"pc_jmp_priority", 32'h0123});
    tick(); load_pc = 0; inc_pc = 0;
    pop_cmp(32'(addr));
  endtask

  task automatic test_halt();
    load_instr(8'h00, 8'h04);
    load_pc = 1; tick(); load_pc = 0;
    halt = 1; inc_pc = 1;
    sb.push_back('{"halt_pc", 32'h0005}); sb.push_back('{"halt_flag", 32'd1});
    tick(); halt = 0;
    pop_cmp(32'(addr)); pop_cmp(32'(halted));

    load_ir = 1; load_acc = 1; rd = 1; datactl_ena = 1; data_in = 8'hA5;
    sb.push_back('{"halt_pc_frozen", 32'h0005});
    sb.push_back('{"halt_ir_frozen", 32'd0});
    sb.push_back('{"halt_acc_frozen", 32'h0F});
    sb.push_back('{"halt_mem_rd", 32'd0});
    sb.push_back('{"halt_data_oe", 32'd0});
    tick(); tick();
    pop_cmp(32'(addr)); pop_cmp(32'(opcode)); pop_cmp(32'(data_out));
    pop_cmp(32'(mem_rd)); pop_cmp(32'(data_oe));

    do_reset(); #1;
    sb.push_back('{"halt_rst_flag", 32'd0}); sb.push_back('{"halt_rst_pc", 32'd0});
    sb.push_back('{"halt_rst_zero", 32'd1});
    pop_cmp(32'(halted)); pop_cmp(32'(addr)); pop_cmp(32'(zero));
  endtask

  task automatic test_boundary();
    load_ir = 1; data_in = 8'h3C; tick();
    load_ir = 0; tick();
    sb.push_back('{"lone_ir_opcode", 32'd1}); sb.push_back('{"lone_ir_cnt", 32'd0});
    pop_cmp(32'(opcode)); pop_cmp(32'(instr_cnt));

    load_ir = 1; data_in = 8'hA0; tick();
    load_ir = 0; tick();
    sb.push_back('{"relone_ir_opcode", 32'd5}); sb.push_back('{"relone_ir_cnt", 32'd0});
    pop_cmp(32'(opcode)); pop_cmp(32'(instr_cnt));

    rd = 1; wr = 1; #1;
    sb.push_back('{"buserr_mem_wr", 32'd1});
    pop_cmp(32'(mem_wr));
    tick(); rd = 0; wr = 0; tick(); tick();
    sb.push_back('{"buserr_sticky", 32'd1});
    pop_cmp(32'(bus_err));
    do_reset(); #1;
    sb.push_back('{"buserr_rst", 32'd0});
    pop_cmp(32'(bus_err));
  endtask

  initial begin
    idle();
    test_reset();
    test_fetch();
    test_alu();
    test_pc();
    test_halt();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
